phase_sequencer: RTL

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

---
 rtl/ps_pkg.sv | 30 +++
 rtl/phase_sequencer_edge_detect.sv | 27 ++
 rtl/phase_sequencer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/ps_pkg.sv
// Shared definitions for the instruction phase sequencer: controller states,
// phase index encoding and the phase-to-strobe helper.
package ps_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;

  localparam logic [3:0] P1         = 4'd0;
  localparam logic [3:0] P2         = 4'd1;
  localparam logic [3:0] P3         = 4'd2;
  localparam logic [3:0] P4         = 4'd3;
  localparam logic [3:0] P5         = 4'd4;
  localparam logic [3:0] PHASE_IDLE = 4'hF;

  localparam int NUM_PHASES = 5;

  // One-hot strobe for a phase index; any index outside P1..P5 gives all zeros.
  function automatic logic [NUM_PHASES-1:0] phase_onehot(input logic [3:0] p);
    logic [NUM_PHASES-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (p == 4'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

endpackage

// File: rtl/phase_sequencer_edge_detect.sv
// Rising-edge detector for a debounced level request. The detector only arms
// once the input has been seen low after reset, so a request held high
// through reset cannot masquerade as a fresh edge.
module edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic sig_i,
  output logic rise_o
);

  logic prev_q;
  logic armed_q;

  // Remember the previous level and arm after the first low sample.
  always_ff @(posedge clock) begin
    if (!reset) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q  <= sig_i;
      armed_q <= armed_q | ~sig_i;
    end
  end

  assign rise_o = sig_i & ~prev_q & armed_q;

endmodule

// File: rtl/phase_sequencer.sv
// Five-phase instruction sequencer with run/stop control, memory-wait stalls
// in P1/P5, halt handling and a retired-instruction counter.
// Optional feature: define SINGLE_STEP_EN to add the step input, which runs
// exactly one instruction from IDLE.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | stopped; no phase strobe, phase index reads 4'hF
// ST_RUN   | executing instructions back to back
// ST_DRAIN | finishing the current instruction, then back to ST_IDLE
module phase_sequencer
  import ps_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        exec,
  input  logic        halt,
  input  logic        mem_wait,
`ifdef SINGLE_STEP_EN
  input  logic        step,
`endif
  output logic [4:0]  phase_bus,
  output logic [3:0]  phase,
  output logic        running,
  output logic        instr_done,
  output logic [15:0] instr_count
);

  state_t      state_q, state_d;
  logic [3:0]  phase_q, phase_d;
  logic [15:0] count_q, count_d;
  logic        exec_rise;
  logic        last_p5;

  edge_detect u_exec_edge (
    .clock  (clock),
    .reset  (reset),
    .sig_i  (exec),
    .rise_o (exec_rise)
  );

`ifdef SINGLE_STEP_EN
  logic step_rise;

  edge_detect u_step_edge (
    .clock  (clock),
    .reset  (reset),
    .sig_i  (step),
    .rise_o (step_rise)
  );
`endif

  // P5 ends on the first cycle memory is ready; that is where the instruction retires.
  assign last_p5 = (state_q != ST_IDLE) && (phase_q == P5) && !mem_wait;

  // Next-state, next-phase and retire-count logic.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (exec_rise) begin
          state_d = ST_RUN;
          phase_d = P1;
        end
`ifdef SINGLE_STEP_EN
        else if (step_rise) begin
          state_d = ST_DRAIN;
          phase_d = P1;
        end
`endif
      end
      default: begin
        // A stop request only marks the instruction for draining; it never aborts it.
        if ((state_q == ST_RUN) && exec_rise) state_d = ST_DRAIN;
        case (phase_q)
          P1: if (!mem_wait) phase_d = P2;
          P2: phase_d = P3;
          P3: phase_d = P4;
          P4: phase_d = P5;
          P5: begin
            if (!mem_wait) begin
              count_d = count_q + 16'd1;
              if (halt || (state_d == ST_DRAIN)) begin
                state_d = ST_IDLE;
                phase_d = PHASE_IDLE;
              end else begin
                phase_d = P1;
              end
            end
          end
          default: begin
            state_d = ST_IDLE;
            phase_d = PHASE_IDLE;
          end
        endcase
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      phase_q <= PHASE_IDLE;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      count_q <= count_d;
    end
  end

  assign phase_bus   = phase_onehot(phase_q);
  assign phase       = phase_q;
  assign running     = (state_q != ST_IDLE);
  // Suppressed while reset is asserted so an abandoned instruction never reports done.
  assign instr_done  = last_p5 && reset;
  assign instr_count = count_q;

endmodule
